// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg
//   Shared definitions for the bit-serial adder/subtractor.
//   - state_t   : controller states (IDLE, SHIFT, DONE)
//   - WIDTH_DEF : default operand/result width
package serial_adder_pkg;

    localparam int WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/full_adder.sv
// full_adder
//   One-bit full adder, purely combinational.
//   Ports: a, b, cin (inputs), sum, cout (outputs).
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic w_p;

    assign w_p  = a ^ b;
    assign sum  = w_p ^ cin;
    assign cout = (a & b) | (cin & w_p);

endmodule

// File: rtl/serial_adder.sv
// serial_adder
//   Bit-serial add/subtract, LSB first, one full-adder step per clock.
//   Ports:
//     clk, rst_n        : clock, asynchronous active-low reset
//     start             : request an operation (sampled in IDLE only)
//     a, b, cin, sub    : operands, carry/borrow-in, 0=add 1=subtract
//     busy              : high while bits are being processed (SHIFT)
//     done              : one-cycle pulse, results valid (DONE)
//     sum, cout, ovf    : result, raw MSB carry-out, signed overflow;
//                         held until the next accepted start
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic [CNT_W-1:0] r_cnt;
    logic             r_carry;
    logic             r_cout;
    logic             r_ovf;

    logic             w_accept;
    logic             w_last;
    logic             w_fa_sum;
    logic             w_fa_cout;

    assign w_accept = (r_state == IDLE) && start;
    assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

    // ------------------------------------------------------------------
    // Controller
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) w_state_nxt = SHIFT;
            end
            SHIFT: begin
                busy = 1'b1;
                if (w_last) w_state_nxt = DONE;
            end
            DONE: begin
                done        = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: one full-adder step on the LSBs of the operand shifters
    // ------------------------------------------------------------------
    full_adder u_fa (
        .a    (r_a[0]),
        .b    (r_b[0]),
        .cin  (r_carry),
        .sum  (w_fa_sum),
        .cout (w_fa_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            // Subtract is folded in here: B is stored inverted and the
            // initial carry is cin^sub, so the serial loop only ever adds.
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            r_carry <= cin ^ sub;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (r_state == SHIFT) begin
            r_a     <= r_a >> 1;
            r_b     <= r_b >> 1;
            // Result bits enter at the top; after WIDTH steps bit 0 sits at LSB.
            r_sum   <= {w_fa_sum, r_sum[WIDTH-1:1]};
            r_carry <= w_fa_cout;
            r_cnt   <= r_cnt + 1'b1;
            if (w_last) begin
                r_cout <= w_fa_cout;
                // r_carry is the carry into the MSB on this step.
                r_ovf  <= r_carry ^ w_fa_cout;
            end
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;
    assign ovf  = r_ovf;

endmodule
